// File: rtl/bbox_msg_scheduler.sv
// Bounding-box report scheduler: every MSG_INTERVAL frames, snapshot all colour boxes and write one
// 3-word {id, min, max} message per non-empty colour into the CPU FIFO, colours served round-robin.
module bbox_msg_scheduler #(
    parameter int NUM_COLOURS  = 4,
    parameter int COORD_W      = 11,
    parameter int MSG_INTERVAL = 6,
    parameter int FIFO_DEPTH   = 256,
    parameter int USEDW_W      = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             frame_done,
    input  logic [NUM_COLOURS*4*COORD_W-1:0] bbox_bus,
    input  logic                             enable,
    input  logic                             fifo_flush,
    input  logic [USEDW_W-1:0]               fifo_usedw,
    output logic [31:0]                      fifo_wrdata,
    output logic                             fifo_wrreq,
    output logic                             busy,
    output logic [15:0]                      overrun_count
);

    localparam int CW    = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1;
    localparam int FCW   = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;
    localparam int BOX_W = 4 * COORD_W;
    localparam logic [FCW-1:0] FRAME_RELOAD = FCW'(MSG_INTERVAL - 1);
    localparam logic [CW-1:0]  LAST_COLOUR  = CW'(NUM_COLOURS - 1);
    localparam int unsigned    ROOM_LIMIT   = FIFO_DEPTH - 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT,
        S_ID,
        S_MIN,
        S_MAX,
        S_GAP
    } state_t;

    state_t state, state_nxt;

    logic [NUM_COLOURS-1:0][BOX_W-1:0] bbox_in;
    logic [NUM_COLOURS-1:0][BOX_W-1:0] snap;
    logic [NUM_COLOURS-1:0]            valid_mask;
    logic [NUM_COLOURS-1:0]            pending;
    logic [FCW-1:0]                    frame_cnt;
    logic [CW-1:0]                     rr_ptr;
    logic [CW-1:0]                     cur;
    logic [CW-1:0]                     sel_idx;
    logic [31:0]                       wrdata_nxt;
    logic                              trigger;
    logic                              accept;
    logic                              has_room;

    assign bbox_in = bbox_bus;

    // Field 0 is x_min (most significant), then y_min, x_max, y_max.
    function automatic logic [COORD_W-1:0] fld(input logic [BOX_W-1:0] box, input int idx);
        return box[(3 - idx) * COORD_W +: COORD_W];
    endfunction

    assign trigger  = frame_done && (frame_cnt == '0);
    assign accept   = (state == S_IDLE) && trigger && enable && !fifo_flush;
    assign has_room = 32'(fifo_usedw) < ROOM_LIMIT;

    always_comb begin
        valid_mask = '0;
        for (int c = 0; c < NUM_COLOURS; c++) begin
            valid_mask[c] = (fld(bbox_in[c], 0) <= fld(bbox_in[c], 2)) &&
                            (fld(bbox_in[c], 1) <= fld(bbox_in[c], 3));
        end
    end

    // First pending colour at or after rr_ptr, wrapping.
    always_comb begin
        logic          found;
        logic [CW-1:0] cand;
        sel_idx = rr_ptr;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_COLOURS; i++) begin
            cand = CW'((int'(rr_ptr) + i) % NUM_COLOURS);
            if (!found && pending[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (fifo_flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (accept && (valid_mask != '0)) state_nxt = S_SELECT;
                S_SELECT: state_nxt = S_WAIT;
                S_WAIT:   if (has_room) state_nxt = S_ID;
                S_ID:     state_nxt = S_MIN;
                S_MIN:    state_nxt = S_MAX;
                S_MAX:    state_nxt = S_GAP;
                S_GAP:    state_nxt = (pending != '0) ? S_SELECT : S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= (frame_cnt == '0) ? FRAME_RELOAD : frame_cnt - 1'b1;
        end
    end

    // A flush takes the coincident trigger with it, so it is not an overrun.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun_count <= '0;
        end else if (trigger && (state != S_IDLE) && !fifo_flush && (overrun_count != 16'hFFFF)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= '0;
            snap    <= '0;
            cur     <= '0;
            rr_ptr  <= '0;
        end else if (fifo_flush) begin
            pending <= '0;
        end else begin
            if (accept) begin
                snap    <= bbox_in;
                pending <= valid_mask;
            end
            if (state == S_SELECT) begin
                cur <= sel_idx;
            end
            if (state == S_MAX) begin
                pending[cur] <= 1'b0;
                rr_ptr       <= (cur == LAST_COLOUR) ? '0 : cur + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they line up exactly with ID/MIN/MAX.
    always_comb begin
        wrdata_nxt = '0;
        case (state_nxt)
            S_ID:    wrdata_nxt = 32'(cur) + 32'd1;
            S_MIN:   wrdata_nxt = {16'(fld(snap[cur], 0)), 16'(fld(snap[cur], 1))};
            S_MAX:   wrdata_nxt = {16'(fld(snap[cur], 2)), 16'(fld(snap[cur], 3))};
            default: wrdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fifo_wrreq  <= 1'b0;
            fifo_wrdata <= '0;
            busy        <= 1'b0;
        end else begin
            fifo_wrreq  <= (state_nxt == S_ID) || (state_nxt == S_MIN) || (state_nxt == S_MAX);
            fifo_wrdata <= wrdata_nxt;
            busy        <= (state_nxt != S_IDLE);
        end
    end

endmodule
